// File: rtl/uadd_pkg.sv
// Shared definitions for the segmented unsigned add/subtract pipeline.
// Op encodings and segment geometry helpers used by the datapath.
package uadd_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   function automatic int seg_width(input int width, input int segs);
      return width / segs;
   endfunction

   function automatic bit seg_ok(input int width, input int segs);
      return (segs >= 1) && (segs <= width) && ((width % segs) == 0);
   endfunction

endpackage

// File: rtl/uadd_seg.sv
// One registered slice of the carry chain.
// Adds two operand slices plus carry-in and holds sum and carry-out.
module uadd_seg #(
   parameter int SEG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [SEG_W-1:0] a,
   input  logic [SEG_W-1:0] b,
   input  logic             cin,
   output logic [SEG_W-1:0] sum,
   output logic             cout
);

   logic [SEG_W:0] total;

   // slice adder with carry in and carry out
   always_comb begin
      total = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, cin};
   end

   // slice result register, frozen while the pipe stalls
   always_ff @(posedge clk) begin
      if (rst) begin
         sum  <= '0;
         cout <= 1'b0;
      end else if (en) begin
         sum  <= total[SEG_W-1:0];
         cout <= total[SEG_W];
      end
   end

endmodule

// File: rtl/uadd_pipe.sv
// Registered unsigned add/subtract with a carry chain cut into SEGS stages.
// Valid/ready flow control, optional saturation, carry/borrow flag in the MSB.
module uadd_pipe
   import uadd_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SEGS  = 2,
   parameter bit SAT   = 1'b0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] opa_i,
   input  logic [WIDTH-1:0] opb_i,
   input  logic             op_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH:0]   sum_o
);

   localparam int SEG_W = seg_width(WIDTH, SEGS);

   if (!seg_ok(WIDTH, SEGS)) begin : g_bad_cfg
      $error("uadd_pipe: SEGS must divide WIDTH and lie in 1..WIDTH");
   end

   logic             advance;
   logic [SEGS:0]    vld;
   logic [SEGS:0]    op_q;
   logic [WIDTH-1:0] a_q [SEGS];
   logic [WIDTH-1:0] b_q [SEGS];
   logic [WIDTH-1:0] lo_q [1:SEGS];
   logic [WIDTH-1:0] res [1:SEGS];
   logic [SEG_W-1:0] seg_sum [SEGS];
   logic [SEGS-1:0]  cout;
   logic [SEGS-1:0]  cin;
   logic [WIDTH-1:0] low;
   logic             flag;

   assign valid_o = vld[SEGS];
   assign advance = !valid_o || ready_i;
   assign ready_o = advance && !rst_i;

   // input register plus skew registers for op, operands and finished slices
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld  <= '0;
         op_q <= '0;
         for (int s = 0; s < SEGS; s++) begin
            a_q[s] <= '0;
            b_q[s] <= '0;
         end
         for (int s = 1; s <= SEGS; s++) begin
            lo_q[s] <= '0;
         end
      end else if (advance) begin
         vld[0]  <= valid_i;
         op_q[0] <= op_i;
         a_q[0]  <= opa_i;
         b_q[0]  <= (op_i == OP_SUB) ? ~opb_i : opb_i;
         for (int s = 1; s <= SEGS; s++) begin
            vld[s]  <= vld[s-1];
            op_q[s] <= op_q[s-1];
         end
         for (int s = 1; s < SEGS; s++) begin
            a_q[s] <= a_q[s-1];
            b_q[s] <= b_q[s-1];
         end
         lo_q[1] <= '0;
         for (int s = 2; s <= SEGS; s++) begin
            lo_q[s] <= res[s-1];
         end
      end
   end

   // segment 0 takes op as carry-in (the +1 of two's complement)
   always_comb begin
      cin[0] = op_q[0];
      for (int s = 1; s < SEGS; s++) begin
         cin[s] = cout[s-1];
      end
   end

   for (genvar s = 0; s < SEGS; s++) begin : g_seg
      uadd_seg #(
         .SEG_W(SEG_W)
      ) u_seg (
         .clk  (clk_i),
         .rst  (rst_i),
         .en   (advance),
         .a    (a_q[s][s*SEG_W +: SEG_W]),
         .b    (b_q[s][s*SEG_W +: SEG_W]),
         .cin  (cin[s]),
         .sum  (seg_sum[s]),
         .cout (cout[s])
      );
   end

   // merge each stage's fresh slice into the skewed lower result bits
   always_comb begin
      for (int s = 1; s <= SEGS; s++) begin
         res[s] = lo_q[s];
         res[s][(s-1)*SEG_W +: SEG_W] = seg_sum[s-1];
      end
   end

   // final stage: carry/borrow flag and optional clamp
   always_comb begin
      flag = cout[SEGS-1] ^ (op_q[SEGS] == OP_SUB);
      low  = res[SEGS];
      if (SAT && flag) begin
         low = {WIDTH{op_q[SEGS] == OP_ADD}};
      end
   end

   assign sum_o = {flag, low};

endmodule
